trace_checker: RTL and testbench

Hardware commit-trace checker for the 16-bit single-cycle CPU. It samples the same commit signals the simulation bench logs: PC, register write, memory read/write and halt. It classifies each committed instruction as a trace record and compares it against a stream of expected records supplied by an external reader such as a ROM walker, a host FIFO or a bench driver. The block reports pass on a matching halt, and reports fail with a code and the failing instruction number on the first divergence. It sits beside the `cpu` instance and needs no changes to the CPU datapath.

---
 rtl/trace_checker.sv | 191 +++++++++++++++++++
 tb/tb_trace_checker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// Commit-trace checker: classifies CPU commits, queues them and compares them against an expected record stream.
// Optional watchdog compiled in when the macro TRACE_CHK_TIMEOUT_EN is defined.
module trace_checker #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [15:0] pc,
    input  logic        reg_write,
    input  logic [3:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        hlt,
    input  logic        exp_valid,
    input  logic [54:0] exp_record,
    output logic        exp_ready,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [2:0]  fail_code,
    output logic [15:0] fail_inum,
    output logic [15:0] inst_count,
    output logic [31:0] cycle_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] K_NOP   = 3'd0;
    localparam logic [2:0] K_REG   = 3'd1;
    localparam logic [2:0] K_LOAD  = 3'd2;
    localparam logic [2:0] K_STORE = 3'd3;
    localparam logic [2:0] K_HALT  = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [3:0]  rd;
        logic [15:0] value;
        logic [15:0] addr;
    } rec_t;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    rec_t        mem_q [DEPTH];
    logic [2:0]  fail_code_q, fail_code_d;
    logic [15:0] fail_inum_q, fail_inum_d;
    logic [15:0] inst_count_q, inst_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        pass_q, fail_q, done_q;

    rec_t        commit_rec_c, head_c, exp_c;
    logic        empty_c, full_c, push_req_c, push_c, pop_c, overflow_c, wd_expire_c;
    logic [2:0]  cmp_code_c;

    // Classify the committing instruction; earlier conditions win.
    always_comb begin
        commit_rec_c      = '0;
        commit_rec_c.pc   = pc;
        commit_rec_c.rd   = write_reg;
        commit_rec_c.addr = mem_addr;
        if (reg_write && mem_read) begin
            commit_rec_c.kind  = K_LOAD;
            commit_rec_c.value = write_data;
        end else if (reg_write) begin
            commit_rec_c.kind  = K_REG;
            commit_rec_c.value = write_data;
        end else if (hlt) begin
            commit_rec_c.kind  = K_HALT;
        end else if (mem_write) begin
            commit_rec_c.kind  = K_STORE;
            commit_rec_c.value = mem_data;
        end else begin
            commit_rec_c.kind  = K_NOP;
        end
    end

    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_c     = mem_q[rd_ptr_q[AW-1:0]];
    assign exp_c      = exp_record;
    assign exp_ready  = (state_q == S_RUN) && !empty_c;
    assign pop_c      = exp_valid && exp_ready;
    assign push_req_c = (state_q == S_RUN) && commit_valid;
    assign push_c     = push_req_c && (!full_c || pop_c);
    assign overflow_c = push_req_c && full_c && !pop_c;

`ifdef TRACE_CHK_TIMEOUT_EN
    assign wd_expire_c = (state_q == S_RUN) && (cycle_count_q == 32'(MAX_CYCLES - 1));
`else
    // Watchdog not built; the limit is referenced only to keep the parameter live.
    assign wd_expire_c = 1'b0 && (cycle_count_q == 32'(MAX_CYCLES - 1));
`endif

    // First mismatching field of the FIFO head against the expected record.
    always_comb begin
        cmp_code_c = 3'd0;
        if (head_c.kind != exp_c.kind) begin
            cmp_code_c = 3'd1;
        end else if (head_c.pc != exp_c.pc) begin
            cmp_code_c = 3'd2;
        end else if ((head_c.kind == K_REG || head_c.kind == K_LOAD) && head_c.rd != exp_c.rd) begin
            cmp_code_c = 3'd3;
        end else if ((head_c.kind == K_REG || head_c.kind == K_LOAD || head_c.kind == K_STORE)
                     && head_c.value != exp_c.value) begin
            cmp_code_c = 3'd4;
        end else if ((head_c.kind == K_LOAD || head_c.kind == K_STORE) && head_c.addr != exp_c.addr) begin
            cmp_code_c = 3'd5;
        end
    end

    // Next state: mismatch beats overflow beats watchdog beats a normal match.
    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        fail_inum_d   = fail_inum_q;
        inst_count_d  = inst_count_q;
        cycle_count_d = cycle_count_q;
        if (state_q == S_RUN) begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (pop_c && cmp_code_c != 3'd0) begin
                state_d     = S_FAIL;
                fail_code_d = cmp_code_c;
                fail_inum_d = inst_count_q;
            end else if (overflow_c) begin
                state_d     = S_FAIL;
                fail_code_d = 3'd6;
                fail_inum_d = inst_count_q + 16'(DEPTH);
            end else if (wd_expire_c) begin
                state_d     = S_FAIL;
                fail_code_d = 3'd7;
                fail_inum_d = inst_count_q;
            end else if (pop_c) begin
                inst_count_d = inst_count_q + 16'd1;
                if (head_c.kind == K_HALT) begin
                    state_d = S_PASS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fail_code_q   <= 3'd0;
            fail_inum_q   <= 16'd0;
            inst_count_q  <= 16'd0;
            cycle_count_q <= 32'd0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            fail_inum_q   <= fail_inum_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            pass_q        <= (state_d == S_PASS);
            fail_q        <= (state_d == S_FAIL);
            done_q        <= (state_d != S_RUN);
            if (push_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Record storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= commit_rec_c;
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fail_code_q;
    assign fail_inum   = fail_inum_q;
    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: directed traces, final results checked when done rises.
module tb_trace_checker;

    localparam int unsigned DEPTH = 8;

    logic        clk, rst, commit_valid, reg_write, mem_read, mem_write, hlt, exp_valid;
    logic [15:0] pc, write_data, mem_addr, mem_data;
    logic [3:0]  write_reg;
    logic [54:0] exp_record;
    logic        exp_ready, done, pass, fail;
    logic [2:0]  fail_code;
    logic [15:0] fail_inum, inst_count;
    logic [31:0] cycle_count;

    trace_checker #(.DEPTH(DEPTH), .MAX_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .hlt(hlt), .exp_valid(exp_valid), .exp_record(exp_record), .exp_ready(exp_ready),
        .done(done), .pass(pass), .fail(fail), .fail_code(fail_code), .fail_inum(fail_inum),
        .inst_count(inst_count), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        f;
        logic [2:0]  code;
        logic [15:0] inum;
        logic [15:0] inst;
    } res_t;

    typedef struct {
        logic        rw, mr, mw, h;
        logic [15:0] pc, wd, ma, md;
        logic [3:0]  wr;
        logic [54:0] er;
        logic [2:0]  code;
    } case_t;

    res_t        sb_q[$];
    logic [54:0] exp_q[$];
    logic        exp_en, hs, mon_done_prev;
    int          n_vec, n_miss;

    function automatic logic [54:0] rec(input logic [2:0] k, input logic [15:0] p, input logic [3:0] r,
                                        input logic [15:0] v, input logic [15:0] a);
        return {k, p, r, v, a};
    endfunction

    function automatic res_t mk_res(input logic p, input logic f, input logic [2:0] c,
                                    input logic [15:0] inum, input logic [15:0] inst);
        res_t r;
        r.p = p; r.f = f; r.code = c; r.inum = inum; r.inst = inst;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic commit(input logic rw, input logic mr, input logic mw, input logic h,
                          input logic [15:0] p, input logic [3:0] r, input logic [15:0] wd,
                          input logic [15:0] ma, input logic [15:0] md);
        commit_valid = 1'b1; reg_write = rw; mem_read = mr; mem_write = mw; hlt = h;
        pc = p; write_reg = r; write_data = wd; mem_addr = ma; mem_data = md;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        commit_valid = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hlt = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; exp_en = 1'b0; commit_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        if (done !== 1'b1) begin
            n_vec++; n_miss++;
            $display("FAIL wait_done: done still %b after %0d cycles, expected 1", done, budget);
        end
        @(negedge clk); #1;
    endtask

    // Expected-stream driver: present the queue head, pop it when the handshake completes.
    initial begin
        exp_valid = 1'b0; exp_record = '0; hs = 1'b0;
        forever begin
            @(negedge clk);
            exp_valid  = exp_en && (exp_q.size() != 0);
            exp_record = exp_valid ? exp_q[0] : '0;
            #1 hs = exp_valid && exp_ready;
            @(posedge clk);
            if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    // Monitor: each rising done is matched against the next scoreboard entry.
    initial begin
        res_t e;
        mon_done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_done_prev = 1'b0;
            end else if (done === 1'b1 && !mon_done_prev) begin
                mon_done_prev = 1'b1;
                if (sb_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_done: done=1 code=%0d, expected no result", fail_code);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pass", 32'(pass), 32'(e.p));
                    check("sb_fail", 32'(fail), 32'(e.f));
                    check("sb_fail_code", 32'(fail_code), 32'(e.code));
                    check("sb_fail_inum", 32'(fail_inum), 32'(e.inum));
                    check("sb_inst_count", 32'(inst_count), 32'(e.inst));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        case_t cases[5];
        logic  ready_seen;
        n_vec = 0; n_miss = 0; exp_en = 1'b0;
        commit_valid = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hlt = 1'b0;
        pc = '0; write_reg = '0; write_data = '0; mem_addr = '0; mem_data = '0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_fail_code", 32'(fail_code), 0);
        check("rst_fail_inum", 32'(fail_inum), 0);
        check("rst_inst_count", 32'(inst_count), 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_exp_ready", 32'(exp_ready), 0);
        rst = 1'b0;

        // Matching REG / STORE / HALT trace
        do_reset();
        exp_q = '{rec(3'd1, 16'h0000, 4'd1, 16'h0005, 16'h0000),
                  rec(3'd3, 16'h0002, 4'd0, 16'h0005, 16'h0010),
                  rec(3'd4, 16'h0004, 4'd0, 16'h0000, 16'h0000)};
        exp_en = 1'b1;
        sb_q.push_back(mk_res(1'b1, 1'b0, 3'd0, 16'd0, 16'd3));
        commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 16'h0005, 16'h0000, 16'h0000);
        commit(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 4'd0, 16'h0000, 16'h0010, 16'h0005);
        commit(1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        check("t1_pass_one_cycle_after_halt", 32'(pass), 0);
        idle(1);
        check("t1_pass_two_cycles_after_halt", 32'(pass), 1);
        check("t1_exp_ready_after_pass", 32'(exp_ready), 0);
        idle(2);
        check("t1_cycle_count_frozen", cycle_count, 4);

        // Value mismatch on record 0, later records must not be accepted
        do_reset();
        exp_q = '{rec(3'd1, 16'h0000, 4'd1, 16'h0006, 16'h0000),
                  rec(3'd1, 16'h0002, 4'd2, 16'h0007, 16'h0000)};
        exp_en = 1'b1;
        sb_q.push_back(mk_res(1'b0, 1'b1, 3'd4, 16'd0, 16'd0));
        commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 16'h0005, 16'h0000, 16'h0000);
        commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 4'd2, 16'h0007, 16'h0000, 16'h0000);
        commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 4'd3, 16'h0008, 16'h0000, 16'h0000);
        wait_done(6);
        ready_seen = 1'b0;
        repeat (3) begin
            commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 4'd4, 16'h0009, 16'h0000, 16'h0000);
            ready_seen = ready_seen | (exp_ready !== 1'b0);
        end
        check("t2_exp_ready_stays_low", 32'(ready_seen), 0);

        // Stalled stream: DEPTH commits fill the FIFO, one more overflows
        do_reset();
        sb_q.push_back(mk_res(1'b0, 1'b1, 3'd6, 16'(DEPTH), 16'd0));
        for (int i = 0; i <= DEPTH; i++)
            commit(1'b1, 1'b0, 1'b0, 1'b0, 16'(2*i), 4'(i), 16'(i), 16'h0000, 16'h0000);
        idle(0);
        wait_done(4);
        check("t3_cycle_count_at_overflow", cycle_count, 32'(DEPTH + 1));

        // Push and pop together while full is legal; trace then passes
        do_reset();
        for (int i = 0; i <= DEPTH; i++)
            exp_q.push_back(rec(3'd1, 16'(2*i), 4'(i), 16'(i), 16'h0000));
        exp_q.push_back(rec(3'd4, 16'(2*(DEPTH+1)), 4'd0, 16'h0000, 16'h0000));
        sb_q.push_back(mk_res(1'b1, 1'b0, 3'd0, 16'd0, 16'(DEPTH + 2)));
        for (int i = 0; i < DEPTH; i++)
            commit(1'b1, 1'b0, 1'b0, 1'b0, 16'(2*i), 4'(i), 16'(i), 16'h0000, 16'h0000);
        exp_en = 1'b1;
        commit(1'b1, 1'b0, 1'b0, 1'b0, 16'(2*DEPTH), 4'(DEPTH), 16'(DEPTH), 16'h0000, 16'h0000);
        commit(1'b0, 1'b0, 1'b0, 1'b1, 16'(2*(DEPTH+1)), 4'd0, 16'h0000, 16'h0000, 16'h0000);
        idle(1);
        wait_done(20);
        check("t3b_no_fail", 32'(fail), 0);

        // Single-record divergences: classification and field order
        cases[0] = '{rw:1'b1, mr:1'b1, mw:1'b0, h:1'b0, pc:16'h0030, wd:16'hBEEF, ma:16'h0020, md:16'h0000,
                     wr:4'd2, er:rec(3'd2, 16'h0030, 4'd2, 16'hBEEF, 16'h0022), code:3'd5};
        cases[1] = '{rw:1'b1, mr:1'b0, mw:1'b0, h:1'b1, pc:16'h0040, wd:16'h0001, ma:16'h0000, md:16'h0000,
                     wr:4'd1, er:rec(3'd4, 16'h0040, 4'd0, 16'h0000, 16'h0000), code:3'd1};
        cases[2] = '{rw:1'b0, mr:1'b0, mw:1'b1, h:1'b0, pc:16'h0050, wd:16'h0000, ma:16'h0008, md:16'h0009,
                     wr:4'd0, er:rec(3'd3, 16'h0052, 4'd0, 16'h0009, 16'h0008), code:3'd2};
        cases[3] = '{rw:1'b1, mr:1'b0, mw:1'b0, h:1'b0, pc:16'h0060, wd:16'h0007, ma:16'h0000, md:16'h0000,
                     wr:4'd3, er:rec(3'd1, 16'h0060, 4'd4, 16'h0007, 16'h0000), code:3'd3};
        cases[4] = '{rw:1'b0, mr:1'b0, mw:1'b1, h:1'b0, pc:16'h0070, wd:16'h0000, ma:16'h0012, md:16'h0034,
                     wr:4'd0, er:rec(3'd3, 16'h0070, 4'd0, 16'h0035, 16'h0012), code:3'd4};
        for (int c = 0; c < 5; c++) begin
            do_reset();
            exp_q.push_back(cases[c].er);
            exp_en = 1'b1;
            sb_q.push_back(mk_res(1'b0, 1'b1, cases[c].code, 16'd0, 16'd0));
            commit(cases[c].rw, cases[c].mr, cases[c].mw, cases[c].h, cases[c].pc, cases[c].wr,
                   cases[c].wd, cases[c].ma, cases[c].md);
            idle(1);
            wait_done(4);
        end

        // NOP compares only kind and pc
        do_reset();
        exp_q = '{rec(3'd0, 16'h0080, 4'd5, 16'h1234, 16'h5678),
                  rec(3'd4, 16'h0082, 4'd9, 16'h0009, 16'h0009)};
        exp_en = 1'b1;
        sb_q.push_back(mk_res(1'b1, 1'b0, 3'd0, 16'd0, 16'd2));
        commit(1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        commit(1'b0, 1'b0, 1'b0, 1'b1, 16'h0082, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        idle(1);
        wait_done(4);

        // Watchdog: 40 matched NOPs, then silence with no HALT
        do_reset();
        for (int i = 0; i < 40; i++) exp_q.push_back(rec(3'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000));
        exp_en = 1'b1;
`ifdef TRACE_CHK_TIMEOUT_EN
        sb_q.push_back(mk_res(1'b0, 1'b1, 3'd7, 16'd40, 16'd40));
`endif
        repeat (40) commit(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 16'h0000, 16'h0000);
`ifdef TRACE_CHK_TIMEOUT_EN
        idle(0);
        wait_done(20);
        check("t5_cycle_count_at_expiry", cycle_count, 50);
`else
        idle(20);
        check("t5_no_done", 32'(done), 0);
        check("t5_inst_count", 32'(inst_count), 40);
        check("t5_cycle_count", cycle_count, 60);
`endif

        // Reset mid-run after 3 matched records, then a fresh trace
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(rec(3'd1, 16'(2*i), 4'(i), 16'(i), 16'h0000));
        exp_en = 1'b1;
        for (int i = 0; i < 4; i++)
            commit(1'b1, 1'b0, 1'b0, 1'b0, 16'(2*i), 4'(i), 16'(i), 16'h0000, 16'h0000);
        check("t6_inst_before_reset", 32'(inst_count), 3);
        rst = 1'b1; exp_en = 1'b0; commit_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_done", 32'(done), 0);
        check("t6_inst_count", 32'(inst_count), 0);
        check("t6_cycle_count", cycle_count, 0);
        check("t6_fifo_empty", 32'(exp_ready), 0);
        rst = 1'b0;
        exp_q = '{rec(3'd1, 16'h0100, 4'd5, 16'h0055, 16'h0000),
                  rec(3'd4, 16'h0102, 4'd0, 16'h0000, 16'h0000)};
        exp_en = 1'b1;
        sb_q.push_back(mk_res(1'b1, 1'b0, 3'd0, 16'd0, 16'd2));
        commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 4'd5, 16'h0055, 16'h0000, 16'h0000);
        commit(1'b0, 1'b0, 1'b0, 1'b1, 16'h0102, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        idle(1);
        wait_done(4);

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
